// File: rtl/cursor_overlay.sv
// cursor_overlay: latches the mouse position once per frame and composites a 5x5 plus-sign cursor over bg_data.
// Defining CURSOR_OVERLAY_BLINK_EN makes the cursor blink (16 frames on, 16 off) from the frame counter.
module cursor_overlay #(
  parameter int          WIDTH         = 96,
  parameter int          HEIGHT        = 64,
  parameter logic [15:0] CURSOR_COLOUR = 16'hFFFF,
  parameter logic [15:0] CLICK_COLOUR  = 16'hF800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_l,
  input  logic [15:0] bg_data,
  output logic [15:0] pixel_data,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y
);
  localparam logic [12:0]        NPIX = 13'(WIDTH * HEIGHT);
  localparam logic [12:0]        COLS = 13'(WIDTH);
  localparam logic signed [13:0] ARM  = 14'sd2;

  function automatic logic [11:0] sat_coord(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic near(input logic signed [13:0] d);
    return (d >= -ARM) && (d <= ARM);
  endfunction

  logic [6:0]         pos_x, lat_x, eff_x;
  logic [5:0]         pos_y, lat_y, eff_y;
  logic               click, eff_click;
  logic [4:0]         frame_cnt;
  logic [12:0]        px, py;
  logic signed [13:0] dx, dy;
  logic               in_range, hit, visible;
  logic [15:0]        pixel_next, pixel_p1;

  // A pixel requested in the frame_begin cycle already sees the new frame's state.
  assign lat_x     = 7'(sat_coord(mouse_x, 12'(WIDTH - 1)));
  assign lat_y     = 6'(sat_coord(mouse_y, 12'(HEIGHT - 1)));
  assign eff_x     = frame_begin ? lat_x : pos_x;
  assign eff_y     = frame_begin ? lat_y : pos_y;
  assign eff_click = frame_begin ? mouse_l : click;

`ifdef CURSOR_OVERLAY_BLINK_EN
  logic [4:0] eff_cnt;
  assign eff_cnt = frame_begin ? frame_cnt + 5'd1 : frame_cnt;
  assign visible = ~eff_cnt[4];
`else
  assign visible = 1'b1;
`endif

  // Decoding from the linear index keeps px within a row, so arms never wrap.
  assign px       = pixel_index % COLS;
  assign py       = pixel_index / COLS;
  assign dx       = $signed({1'b0, px}) - $signed({7'b0, eff_x});
  assign dy       = $signed({1'b0, py}) - $signed({8'b0, eff_y});
  assign in_range = pixel_index < NPIX;
  assign hit      = ((py == {7'b0, eff_y}) && near(dx)) ||
                    ((px == {6'b0, eff_x}) && near(dy));

  always_comb begin
    pixel_next = bg_data;
    if (!in_range)
      pixel_next = 16'h0000;
    else if (hit && visible)
      pixel_next = eff_click ? CLICK_COLOUR : CURSOR_COLOUR;
  end

  // Stage p1: registered composite output and per-frame latched state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= '0;
      pos_y     <= '0;
      click     <= 1'b0;
      frame_cnt <= '0;
      pixel_p1  <= 16'h0000;
    end else begin
      if (frame_begin) begin
        pos_x     <= lat_x;
        pos_y     <= lat_y;
        click     <= mouse_l;
        frame_cnt <= frame_cnt + 5'd1;
      end
      pixel_p1 <= pixel_next;
    end
  end

  assign pixel_data = pixel_p1;
  assign cursor_x   = pos_x;
  assign cursor_y   = pos_y;
endmodule

// File: tb/tb_cursor_overlay.sv
// Self-checking bench for cursor_overlay: directed scenarios plus randomized traffic against a screen-level model.
module tb_cursor_overlay;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [11:0] mouse_x = '0;
  logic [11:0] mouse_y = '0;
  logic        mouse_l = 1'b0;
  logic [15:0] bg_data = '0;
  logic [15:0] pixel_data;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;

  int checks = 0;
  int errors = 0;

  // Model state: cursor position, click, frame count as the screen should see them.
  int          m_cx = 0, m_cy = 0, m_cnt = 0;
  bit          m_click = 0;
  logic [15:0] exp_pix;

  cursor_overlay dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_l(mouse_l), .bg_data(bg_data),
    .pixel_data(pixel_data), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_pix(input int idx, input logic [15:0] bg);
    int x, y;
    bit hit, vis;
    if (idx >= 96 * 64) return 16'h0000;
    x = idx % 96;
    y = idx / 96;
    hit = ((y == m_cy) && (x - m_cx <= 2) && (m_cx - x <= 2)) ||
          ((x == m_cx) && (y - m_cy <= 2) && (m_cy - y <= 2));
    vis = 1'b1;
`ifdef CURSOR_OVERLAY_BLINK_EN
    vis = (m_cnt % 32) < 16;
`endif
    if (hit && vis) return m_click ? 16'hF800 : 16'hFFFF;
    return bg;
  endfunction

  // One clock of stimulus; leaves the expected pixel in exp_pix, sampled 1 time unit after the edge.
  task automatic cycle(input bit fb, input int idx, input logic [15:0] bg);
    frame_begin = fb;
    pixel_index = 13'(idx);
    bg_data     = bg;
    if (fb) begin
      m_cx    = (mouse_x > 12'd95) ? 95 : int'(mouse_x);
      m_cy    = (mouse_y > 12'd63) ? 63 : int'(mouse_y);
      m_click = mouse_l;
      m_cnt   = (m_cnt + 1) % 32;
    end
    exp_pix = model_pix(idx, bg);
    @(posedge clk);
    #1;
    frame_begin = 1'b0;
  endtask

  task automatic model_reset();
    m_cx = 0; m_cy = 0; m_cnt = 0; m_click = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mouse_x = 12'd50; mouse_y = 12'd30; mouse_l = 1'b1;
    frame_begin = 1'b1;
    pixel_index = 13'd100;
    bg_data = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    frame_begin = 1'b0;
    checks++; if (pixel_data !== 16'h0000) begin errors++; $display("FAIL reset_pixel: got %h want 0000", pixel_data); end
    checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL reset_cursor_x: got %0d want 0", cursor_x); end
    checks++; if (cursor_y !== 6'd0) begin errors++; $display("FAIL reset_cursor_y: got %0d want 0", cursor_y); end
    reset = 1'b0;
    model_reset();
    mouse_l = 1'b0;
    cycle(0, 0, 16'h1234);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL reset_origin_pixel: got %h want FFFF", pixel_data); end
  endtask

  task automatic test_basic();
    mouse_x = 12'd5; mouse_y = 12'd3; mouse_l = 1'b0;
    cycle(1, 0, 16'h001F);
    checks++; if (cursor_x !== 7'd5 || cursor_y !== 6'd3) begin errors++; $display("FAIL basic_latch: got (%0d,%0d) want (5,3)", cursor_x, cursor_y); end
    mouse_x = 12'd60; mouse_y = 12'd40;
    cycle(0, 293, 16'h001F);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL basic_293: got %h want FFFF", pixel_data); end
    cycle(0, 295, 16'h001F);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL basic_295: got %h want FFFF", pixel_data); end
    cycle(0, 296, 16'h001F);
    checks++; if (pixel_data !== 16'h001F) begin errors++; $display("FAIL basic_296: got %h want 001F", pixel_data); end
    checks++; if (cursor_x !== 7'd5 || cursor_y !== 6'd3) begin errors++; $display("FAIL basic_hold: got (%0d,%0d) want (5,3)", cursor_x, cursor_y); end
  endtask

  task automatic test_clamp();
    mouse_x = 12'd500; mouse_y = 12'd4000;
    cycle(1, 6143, 16'h0A0A);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL clamp_same_cycle_6143: got %h want FFFF", pixel_data); end
    checks++; if (cursor_x !== 7'd95 || cursor_y !== 6'd63) begin errors++; $display("FAIL clamp_latch: got (%0d,%0d) want (95,63)", cursor_x, cursor_y); end
    cycle(0, 6144, 16'h0A0A);
    checks++; if (pixel_data !== 16'h0000) begin errors++; $display("FAIL clamp_6144: got %h want 0000", pixel_data); end
    cycle(0, 8191, 16'h0A0A);
    checks++; if (pixel_data !== 16'h0000) begin errors++; $display("FAIL clamp_8191: got %h want 0000", pixel_data); end
  endtask

  task automatic test_click();
    mouse_x = 12'd10; mouse_y = 12'd10; mouse_l = 1'b1;
    cycle(1, 0, 16'h0555);
    cycle(0, 970, 16'h0555);
    checks++; if (pixel_data !== 16'hF800) begin errors++; $display("FAIL click_held: got %h want F800", pixel_data); end
    mouse_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 970 + (i % 2) * 96, 16'h0555);
      checks++; if (pixel_data !== 16'hF800) begin errors++; $display("FAIL click_midframe_%0d: got %h want F800", i, pixel_data); end
    end
    cycle(1, 970, 16'h0555);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL click_released: got %h want FFFF", pixel_data); end
  endtask

  task automatic test_edges();
    int idxs[10] = '{0, 1, 2, 3, 95, 96, 192, 288, 191, 97};
    mouse_x = 12'd0; mouse_y = 12'd0; mouse_l = 1'b0;
    cycle(1, 0, 16'h2222);
    foreach (idxs[k]) begin
      cycle(0, idxs[k], 16'h2222);
      checks++; if (pixel_data !== exp_pix) begin errors++; $display("FAIL edge_origin_idx%0d: got %h want %h", idxs[k], pixel_data, exp_pix); end
    end
    mouse_x = 12'd95; mouse_y = 12'd0;
    cycle(1, 0, 16'h3333);
    foreach (idxs[k]) begin
      cycle(0, idxs[k] + 93, 16'h3333);
      checks++; if (pixel_data !== exp_pix) begin errors++; $display("FAIL edge_right_idx%0d: got %h want %h", idxs[k] + 93, pixel_data, exp_pix); end
    end
  endtask

  task automatic test_blink();
    logic [15:0] bg;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    mouse_x = 12'd5; mouse_y = 12'd3; mouse_l = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      bg = 16'($urandom);
      cycle(1, 293, bg);
      checks++; if (pixel_data !== exp_pix) begin errors++; $display("FAIL blink_fb_%0d: got %h want %h", k, pixel_data, exp_pix); end
      cycle(0, 293, bg);
      checks++; if (pixel_data !== exp_pix) begin errors++; $display("FAIL blink_frame_%0d: got %h want %h", k, pixel_data, exp_pix); end
`ifdef CURSOR_OVERLAY_BLINK_EN
      if (k == 16) begin
        checks++; if (pixel_data !== bg) begin errors++; $display("FAIL blink_off16: got %h want %h", pixel_data, bg); end
      end
      if (k == 32) begin
        checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL blink_on32: got %h want FFFF", pixel_data); end
      end
`else
      if (k == 16 || k == 32) begin
        checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL blink_always_%0d: got %h want FFFF", k, pixel_data); end
      end
`endif
    end
  endtask

  task automatic test_reset_midframe();
    mouse_x = 12'd40; mouse_y = 12'd20; mouse_l = 1'b1;
    cycle(1, 20 * 96 + 40, 16'h4444);
    cycle(0, 20 * 96 + 40, 16'h4444);
    checks++; if (cursor_x !== 7'd40 || cursor_y !== 6'd20) begin errors++; $display("FAIL midreset_pre: got (%0d,%0d) want (40,20)", cursor_x, cursor_y); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (pixel_data !== 16'h0000) begin errors++; $display("FAIL midreset_pixel: got %h want 0000", pixel_data); end
    checks++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin errors++; $display("FAIL midreset_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 16'h4444);
    checks++; if (pixel_data !== 16'hFFFF) begin errors++; $display("FAIL midreset_origin: got %h want FFFF", pixel_data); end
  endtask

  task automatic test_random();
    int idx;
    bit fb;
    logic [15:0] bg;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) mouse_x = 12'($urandom);
      else mouse_x = 12'($urandom_range(0, 100));
      if ($urandom_range(0, 7) == 0) mouse_y = 12'($urandom);
      else mouse_y = 12'($urandom_range(0, 68));
      mouse_l = 1'($urandom);
      fb = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        idx = (m_cy + int'($urandom_range(0, 6)) - 3) * 96 + m_cx + int'($urandom_range(0, 6)) - 3;
        if (idx < 0) idx = 0;
        if (idx > 8191) idx = 8191;
      end else begin
        idx = int'($urandom_range(0, 8191));
      end
      bg = 16'($urandom);
      cycle(fb, idx, bg);
      checks++; if (pixel_data !== exp_pix) begin errors++; $display("FAIL random_pixel_%0d idx=%0d: got %h want %h", n, idx, pixel_data, exp_pix); end
      checks++; if (int'(cursor_x) != m_cx || int'(cursor_y) != m_cy) begin errors++; $display("FAIL random_cursor_%0d: got (%0d,%0d) want (%0d,%0d)", n, cursor_x, cursor_y, m_cx, m_cy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_click();
    test_edges();
    test_blink();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
